// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-operand hazard sequencer with stall and flush counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mem_stall_i,
    input  logic             clr_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             id_jump_i,
    input  logic             id_eq_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_dst_i,
    input  logic             mem_memread_i,
    input  logic [4:0]       mem_dst_i,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic [1:0]       pc_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       ex_match, mem_match;
    logic       lu, be, bm;
    logic [1:0] stall_len;
    logic       freeze;

    // Register 0 is hardwired, so writing it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] d, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (d != 5'd0) && ((d == rs) || (uses_rt && (d == rt)));
    endfunction

    assign ex_match  = reg_match(ex_dst_i, id_rs_i, id_rt_i, id_uses_rt_i);
    assign mem_match = reg_match(mem_dst_i, id_rs_i, id_rt_i, id_uses_rt_i);

    assign lu = ex_memread_i & ex_match;
    assign be = id_branch_i & ex_regwrite_i & ex_match;
    assign bm = id_branch_i & mem_memread_i & mem_match;

    // A branch on a value still being loaded in EX needs the load to reach WB.
    always_comb begin
        stall_len = 2'd0;
        if (id_branch_i && ex_memread_i && ex_match) begin
            stall_len = 2'd2;
        end else if (lu || be || bm) begin
            stall_len = 2'd1;
        end
    end

    assign freeze = !rst_i || !start_i || mem_stall_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!freeze) begin
            case (state_q)
                RUN: begin
                    if (stall_len == 2'd2) begin
                        state_d = HOLD;
                        rem_d   = 2'd1;
                    end
                end
                HOLD: begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_o      = 1'b0;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        pc_sel_o     = 2'd0;
        if (!freeze) begin
            if (state_q == HOLD || stall_len != 2'd0) begin
                stall_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                if (id_jump_i) begin
                    pc_sel_o     = 2'd2;
                    ifid_flush_o = 1'b1;
                end else if (id_branch_i && id_eq_i) begin
                    pc_sel_o     = 2'd1;
                    ifid_flush_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!freeze) begin
            if (stall_o && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (ifid_flush_o && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_stall = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  rs = '0, rt = '0;
    logic        uses_rt = 1'b0, branch = 1'b0, jump = 1'b0, eq = 1'b0;
    logic        ex_rw = 1'b0, ex_mr = 1'b0;
    logic [4:0]  ex_dst = '0;
    logic        mem_mr = 1'b0;
    logic [4:0]  mem_dst = '0;
    logic        stall, pc_write, ifid_write, ifid_flush;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic [5:0]  outs;

    int errors = 0;
    int checks = 0;

    assign outs = {stall, pc_write, ifid_write, ifid_flush, pc_sel};

    localparam logic [5:0] O_FRZ   = 6'b0_0_0_0_00;
    localparam logic [5:0] O_STALL = 6'b1_0_0_0_00;
    localparam logic [5:0] O_NORM  = 6'b0_1_1_0_00;
    localparam logic [5:0] O_JUMP  = 6'b0_1_1_1_10;
    localparam logic [5:0] O_TAKEN = 6'b0_1_1_1_01;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(mem_stall), .clr_i(clr),
        .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses_rt),
        .id_branch_i(branch), .id_jump_i(jump), .id_eq_i(eq),
        .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr), .ex_dst_i(ex_dst),
        .mem_memread_i(mem_mr), .mem_dst_i(mem_dst),
        .stall_o(stall), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .ifid_flush_o(ifid_flush), .pc_sel_o(pc_sel),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start, mem_stall;
        logic [4:0] rs, rt;
        logic       uses_rt, branch, jump, eq, ex_rw, ex_mr;
        logic [4:0] ex_dst;
        logic       mem_mr;
        logic [4:0] mem_dst;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        rs = '0; rt = '0; uses_rt = 0; branch = 0; jump = 0; eq = 0;
        ex_rw = 0; ex_mr = 0; ex_dst = '0; mem_mr = 0; mem_dst = '0;
        mem_stall = 0; start = 1;
    endtask

    task automatic clear_counters;
        clr = 1;
        tick;
        clr = 0;
    endtask

    task automatic apply(input vec_t v);
        start = v.start; mem_stall = v.mem_stall; rs = v.rs; rt = v.rt;
        uses_rt = v.uses_rt; branch = v.branch; jump = v.jump; eq = v.eq;
        ex_rw = v.ex_rw; ex_mr = v.ex_mr; ex_dst = v.ex_dst;
        mem_mr = v.mem_mr; mem_dst = v.mem_dst;
    endtask

    task automatic load_beq_hazard;
        ex_mr = 1; ex_rw = 1; ex_dst = 5'd5; branch = 1; rt = 5'd5; uses_rt = 1;
    endtask

    initial begin
        //           st ms rs     rt     urt br jp eq exrw exmr exdst  mmr mdst   exp
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_NORM};
        vecs[1]  = '{1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, O_STALL};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, O_NORM};
        vecs[3]  = '{1'b1, 1'b0, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, O_NORM};
        vecs[4]  = '{1'b1, 1'b0, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, O_STALL};
        vecs[5]  = '{1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0, O_JUMP};
        vecs[6]  = '{1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_TAKEN};
        vecs[7]  = '{1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_NORM};
        vecs[8]  = '{1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, O_STALL};
        vecs[9]  = '{1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, O_NORM};
        vecs[10] = '{1'b1, 1'b0, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, O_STALL};
        vecs[11] = '{1'b1, 1'b0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, O_NORM};
        vecs[12] = '{1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, O_FRZ};
        vecs[13] = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_FRZ};
        vecs[14] = '{1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, O_STALL};
        vecs[15] = '{1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, O_JUMP};

        // Reset state: FREEZE outputs, counters zero.
        #2;
        check("reset_outs", 32'(outs), 32'(O_FRZ));
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        tick;
        rst = 1;
        clear_inputs;
        #1;
        check("post_reset_normal", 32'(outs), 32'(O_NORM));

        // Single-cycle combinational vectors; clr held so counters stay quiet.
        clr = 1;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
        end
        clear_inputs;
        tick;
        clr = 0;

        // Load-use for one cycle.
        clear_counters;
        ex_mr = 1; ex_dst = 5'd2; rs = 5'd2;
        #1;
        check("lu_stall", 32'(outs), 32'(O_STALL));
        tick;
        ex_mr = 0; ex_dst = 0;
        #1;
        check("lu_release", 32'(outs), 32'(O_NORM));
        tick;
        check("lu_stall_cnt", 32'(stall_cnt), 1);

        // Load then dependent beq: two stalls, then taken.
        clear_inputs;
        clear_counters;
        load_beq_hazard;
        eq = 1;
        #1;
        check("lb_stall1", 32'(outs), 32'(O_STALL));
        tick;
        ex_mr = 0; ex_rw = 0; ex_dst = 0;
        #1;
        check("lb_stall2", 32'(outs), 32'(O_STALL));
        tick;
        check("lb_taken", 32'(outs), 32'(O_TAKEN));
        tick;
        check("lb_stall_cnt", 32'(stall_cnt), 2);
        check("lb_flush_cnt", 32'(flush_cnt), 1);

        // mem_stall while in HOLD stretches the stall.
        clear_inputs;
        clear_counters;
        load_beq_hazard;
        tick;
        ex_mr = 0; ex_rw = 0; ex_dst = 0;
        mem_stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("ms_freeze%0d", c), 32'(outs), 32'(O_FRZ));
            check($sformatf("ms_cnt%0d", c), 32'(stall_cnt), 1);
            tick;
        end
        mem_stall = 0;
        #1;
        check("ms_hold_resume", 32'(outs), 32'(O_STALL));
        tick;
        check("ms_normal", 32'(outs), 32'(O_NORM));
        check("ms_stall_cnt", 32'(stall_cnt), 2);

        // Reset asserted while in HOLD.
        clear_inputs;
        clear_counters;
        load_beq_hazard;
        tick;
        check("rh_cnt_before", 32'(stall_cnt), 1);
        clear_inputs;
        rst = 0;
        #1;
        check("rh_outs", 32'(outs), 32'(O_FRZ));
        check("rh_stall_cnt", 32'(stall_cnt), 0);
        tick;
        rst = 1;
        #1;
        check("rh_no_residual", 32'(outs), 32'(O_NORM));
        tick;
        check("rh_cnt_after", 32'(stall_cnt), 0);

        // Saturation, then clear beats increment with a stall still active.
        clear_counters;
        ex_mr = 1; ex_dst = 5'd9; rs = 5'd9;
        repeat (65535) tick;
        check("sat_reach", 32'(stall_cnt), 32'hFFFF);
        tick;
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        check("sat_still_stall", 32'(stall), 1);
        clr = 1;
        tick;
        clr = 0;
        check("clr_wins", 32'(stall_cnt), 0);
        clear_inputs;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the decode stage and detects load-use and branch-operand hazards against the EX and MEM stages. It decides each cycle whether the PC and IF/ID register advance, whether a bubble is injected into ID/EX through the Control unit's Stall_i, and whether IF/ID is flushed on a taken branch or jump. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of the performance counters
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  core run enable; when low, PC and IF/ID hold and the FSM stays in RUN
- mem_stall_i  in  1  data-cache stall; freezes the whole pipeline
- clr_i  in  1  synchronous clear of both counters
- id_rs_i, id_rt_i  in  5  source register fields of the instruction in ID
- id_uses_rt_i  in  1  instruction in ID reads RT (R-type, beq, sw)
- id_branch_i, id_jump_i, id_eq_i  in  1  Branch_o, Jump_o, Eq_o from decode
- ex_regwrite_i, ex_memread_i  in  1  ID/EX RegWrite; ID/EX MemRead != 0
- ex_dst_i  in  5  EX destination register after the RegDst mux
- mem_memread_i  in  1  EX/MEM MemRead != 0
- mem_dst_i  in  5  EX/MEM destination register
- stall_o  out  1  bubble request to Control Stall_i
- pc_write_o, ifid_write_o  out  1  PC and IF/ID update enables
- ifid_flush_o  out  1  zero the IF/ID instruction on the next edge
- pc_sel_o  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Register match: M(d) = (d != 0) & (d == id_rs_i | (id_uses_rt_i & d == id_rt_i)).
- LU (load-use) = ex_memread_i & M(ex_dst_i).
- BE (branch waits on EX) = id_branch_i & ex_regwrite_i & M(ex_dst_i).
- BM (branch waits on MEM load) = id_branch_i & mem_memread_i & M(mem_dst_i).
- Stall length n:
  - n = 2 if id_branch_i & ex_memread_i & M(ex_dst_i).
  - Otherwise n = 1 if LU | BE | BM.
  - Otherwise n = 0.
- FSM states:
  - RUN: hazard is evaluated from the current inputs.
  - HOLD: rem_q (2 bits) stall cycles remain; inputs are ignored.
- Output priority, highest first:
  - FREEZE: rst_i low, start_i low, or mem_stall_i high. stall_o = 0, pc_write_o = 0, ifid_write_o = 0, ifid_flush_o = 0, pc_sel_o = 0. The state and rem_q are held.
  - STALL: state HOLD, or RUN with n > 0. stall_o = 1, pc_write_o = 0, ifid_write_o = 0, ifid_flush_o = 0, pc_sel_o = 0.
  - JUMP: id_jump_i. pc_sel_o = 2, ifid_flush_o = 1, pc_write_o = 1, ifid_write_o = 1.
  - TAKEN: id_branch_i & id_eq_i. pc_sel_o = 1, ifid_flush_o = 1, pc_write_o = 1, ifid_write_o = 1.
  - NORMAL: pc_sel_o = 0, pc_write_o = 1, ifid_write_o = 1, stall_o = 0, ifid_flush_o = 0.
- Transitions (evaluated only when not FREEZE):
  - RUN with n = 2: go to HOLD, rem_q = 1.
  - RUN with n = 1: stay in RUN; the hazard is re-evaluated next cycle.
  - HOLD: decrement rem_q; go to RUN when rem_q reaches 0.
- Counters (both saturate at all-ones; clr_i has priority over increment):
  - stall_cnt_o increments on every non-FREEZE cycle with stall_o = 1.
  - flush_cnt_o increments on every non-FREEZE cycle with ifid_flush_o = 1.

## Timing
- All outputs except the counters are combinational from the current state and inputs, with zero-cycle latency.
- State, rem_q and the counters update on the rising clk_i edge.
- Reset drives state to RUN, rem_q to 0 and both counters to 0. The combinational outputs during reset are the FREEZE values.
- Reset asserted while in HOLD returns the FSM to RUN immediately, with no residual stall after release.
- Load followed by a dependent beq stalls for exactly 2 non-frozen cycles; the branch resolves on the third.
- mem_stall_i stretches any stall: cycles under mem_stall_i neither count nor consume rem_q.
- A branch or jump that arrives together with a hazard stall is not redirected until the stall clears.

## Test plan
- Load-use: ex_memread_i = 1, ex_dst_i = 2, id_rs_i = 2 for one cycle, then the EX inputs are cleared. Required: stall_o = 1, pc_write_o = 0 and ifid_write_o = 0 for exactly 1 cycle, then NORMAL; stall_cnt_o = 1.
- Load then beq: ex_memread_i = 1, ex_regwrite_i = 1, ex_dst_i = 5, id_branch_i = 1, id_rt_i = 5, id_uses_rt_i = 1, with the EX inputs zeroed after the first cycle. Required: stall_o = 1 for 2 cycles; with id_eq_i = 1 the third cycle gives pc_sel_o = 1 and ifid_flush_o = 1; stall_cnt_o = 2 and flush_cnt_o = 1.
- Jump with an independent instruction in EX: id_jump_i = 1. Required: pc_sel_o = 2, ifid_flush_o = 1, pc_write_o = 1, stall_o = 0.
- Register 0 is not a hazard: ex_memread_i = 1, ex_dst_i = 0, id_rs_i = 0. Required: stall_o = 0 and pc_write_o = 1.
- mem_stall in HOLD: enter HOLD, then hold mem_stall_i high for 3 cycles. Required: all enables 0 and stall_cnt_o unchanged during the freeze; after release stall_o = 1 for 1 more cycle, then NORMAL.
- Reset and clear: assert rst_i low during HOLD with nonzero counters. Required: RUN state, counters 0 and no stall after release. Separately, pulse clr_i while stall_cnt_o = 0xFFFF with a stall active. Required: stall_cnt_o = 0, clr_i wins over increment.
